// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: 16-bit subtractor that processes one 4-bit slice
// per clock, using a borrow-lookahead subtract inside each slice.
// A valid/ready handshake accepts operands in IDLE. Four RUN edges follow,
// and the result is held in DONE until the consumer takes it.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed-overflow
// output ovf.
module nibble_serial_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] d,
  output logic        bout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [1:0]  cnt;
  logic        borrow;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [5:0]  slice;
  logic [3:0]  nib_base;

  // Borrow-lookahead 4-bit subtract x - y - bi.
  // Returns {borrow out of bit 3, borrow into bit 3, difference}.
  // p marks bits that propagate an incoming borrow (x == y).
  // g marks bits that generate a borrow (x = 0, y = 1).
  function automatic logic [5:0] nib_sub(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       bi);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = ~(x ^ y);
    g    = ~x & y;
    c[0] = bi;
    c[1] = g[0] | (p[0] & bi);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bi);
    return {c[4], c[3], x ^ y ^ c[3:0]};
  endfunction

  // Select the current nibble and compute its slice.
  always_comb begin
    nib_base = {cnt, 2'b00};
    a_nib    = a_r[nib_base +: 4];
    b_nib    = b_r[nib_base +: 4];
    slice    = nib_sub(a_nib, b_nib, borrow);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (cnt == 2'd3) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture; only written on an accepted handshake, so operands
  // are never overwritten mid-operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // State register, slice counter, borrow chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      borrow <= 1'b0;
      d      <= 16'h0000;
      bout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= 2'd0;
            borrow <= bin;
          end
        end
        RUN: begin
          d[nib_base +: 4] <= slice[3:0];
          borrow           <= slice[5];
          cnt              <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            bout <= slice[5];
`ifdef OVERFLOW_FLAG_EN
            // Signed overflow: borrow into the sign bit differs from
            // the borrow out of it.
            ovf  <= slice[5] ^ slice[4];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Testbench for nibble_serial_subtractor. A scoreboard queue holds the
// expected {ovf, bout, d} for each accepted operation. The overflow
// checks are active when OVERFLOW_FLAG_EN is defined.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [17:0] sb_q[$];

  nibble_serial_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent model: {ovf, bout, d} of x - y - bi.
  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        bi);
    logic [16:0] full;
    int          sr;
    logic        o;
    full = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    sr   = int'($signed(x)) - int'($signed(y)) - int'(bi);
    o    = (sr < -32768) || (sr > 32767);
    return {o, full[16], full[15:0]};
  endfunction

  // Run one operation. The result is held for hold cycles before
  // out_ready is raised. With junk set, new operands are presented
  // during the hold.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xbin, input int hold, input logic junk,
                        input string name);
    logic [17:0] exp;
    int          lat;
    int          w;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s ready_wait: in_ready=%b required 1", name, in_ready);
    else pass_cnt++;
    a         = xa;
    b         = xb;
    bin       = xbin;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sb_q.push_back(model(xa, xb, xbin));
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    total_cnt++;
    if (lat !== 4) $display("FAIL %s latency: got %0d edges required 4", name, lat);
    else pass_cnt++;
    exp = sb_q.pop_front();
    total_cnt++;
    if (d !== exp[15:0]) $display("FAIL %s d: got %h required %h", name, d, exp[15:0]);
    else pass_cnt++;
    total_cnt++;
    if (bout !== exp[16]) $display("FAIL %s bout: got %b required %b", name, bout, exp[16]);
    else pass_cnt++;
`ifdef OVERFLOW_FLAG_EN
    total_cnt++;
    if (ovf !== exp[17]) $display("FAIL %s ovf: got %b required %b", name, ovf, exp[17]);
    else pass_cnt++;
`endif
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        bin      = 1'b1;
        in_valid = 1'b1;
      end
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== exp[15:0] || bout !== exp[16])
        $display("FAIL %s hold%0d: ov=%b rdy=%b d=%h bout=%b required ov=1 rdy=0 d=%h bout=%b",
                 name, i, out_valid, in_ready, d, bout, exp[15:0], exp[16]);
      else pass_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    bin       = 1'b0;
    step();
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 16'h0000 || bout !== 1'b0)
      $display("FAIL reset: rdy=%b ov=%b d=%h bout=%b required 1 0 0000 0",
               in_ready, out_valid, d, bout);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0, "basic_1234");
  endtask

  task automatic test_borrow_ripple();
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, "ripple_b1");
    run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, "ripple_bin");
    run_op(16'h0000, 16'hFFFF, 1'b1, 1, 1'b0, "ripple_full");
  endtask

  task automatic test_hold();
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 3, 1'b1, "hold_a5a5");
    run_op(16'h0100, 16'h0001, 1'b0, 0, 1'b0, "after_hold");
  endtask

  task automatic test_reset_mid();
    a        = 16'h1234;
    b        = 16'h0001;
    bin      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || d !== 16'h0000 || bout !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_mid: ov=%b d=%h bout=%b rdy=%b required 0 0000 0 1",
               out_valid, d, bout, in_ready);
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "post_reset");
  endtask

  task automatic test_overflow();
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, "ovf_neg");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0, "ovf_pos");
    run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, "ovf_none");
    run_op(16'h8000, 16'h0000, 1'b1, 0, 1'b0, "ovf_bin");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 1000; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_hold();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
